zap_bg_load_writer: RTL and testbench



---
 rtl/zap_bg_load_pkg.sv | 12 +
 rtl/zap_bg_load_fifo.sv | 49 ++++
 rtl/zap_bg_load_writer.sv | 109 ++++++++++
 tb/tb_zap_bg_load_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_bg_load_pkg.sv
// Shared constants and types for the background-load write sequencer.
package zap_bg_load_pkg;

    localparam int ZAP_NREGS  = 40;
    localparam int ZAP_RIDX_W = 6;

    typedef logic [ZAP_RIDX_W-1:0] ridx_t;

    // Index reported when a response arrives with nothing queued.
    localparam ridx_t ZAP_VIOL_IDX = 6'h3F;

endpackage

// File: rtl/zap_bg_load_fifo.sv
// In-order FIFO of destination register indices with occupancy count.
module zap_bg_load_fifo
    import zap_bg_load_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic [ZAP_RIDX_W-1:0]        i_push_idx,
    input  logic                         i_pop,
    output logic [ZAP_RIDX_W-1:0]        o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    ridx_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array is deliberately not reset; validity comes only from the pointers and count.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_ptr] <= i_push_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_count <= o_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head = mem[rd_ptr];

endmodule

// File: rtl/zap_bg_load_writer.sv
// Background-load write sequencer: pairs in-order responses with queued indices and pulses a one-hot write.
// Optional ZAP_BG_LOAD_SCOREBOARD_EN: live pending bitmap with duplicate-index stall.
module zap_bg_load_writer
    import zap_bg_load_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int NREGS  = ZAP_NREGS,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    input  logic [ZAP_RIDX_W-1:0] i_req_idx,
    output logic                  o_req_ready,
    input  logic                  i_rsp_valid,
    input  logic [DATA_W-1:0]     i_rsp_data,
    input  logic                  i_rsp_err,
    output logic [NREGS-1:0]      o_wr_addr_c,
    output logic [DATA_W-1:0]     o_wr_data_c,
    output logic [NREGS-1:0]      o_pending,
    output logic                  o_err,
    output logic [ZAP_RIDX_W-1:0] o_err_idx,
    output logic                  o_busy
);

    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [ZAP_RIDX_W-1:0] head;
    logic [NREGS-1:0]      head_onehot;
    logic                  req_in_range;
    logic                  blocked;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  req_bad;
    logic                  rsp_bad;
    logic                  wr_fire;

    zap_bg_load_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (push),
        .i_push_idx (i_req_idx),
        .i_pop      (pop),
        .o_head     (head),
        .o_count    (count)
    );

    assign req_in_range = int'(i_req_idx) < NREGS;

`ifdef ZAP_BG_LOAD_SCOREBOARD_EN
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] err_clear;

    assign blocked   = req_in_range && o_pending[i_req_idx];
    assign set_mask  = push ? (NREGS'(1) << i_req_idx) : '0;
    assign err_clear = (pop && i_rsp_err) ? head_onehot : '0;

    // Write-clears land on the edge ending the pulse; a same-edge set still wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pending <= '0;
        end else begin
            o_pending <= (o_pending & ~o_wr_addr_c & ~err_clear) | set_mask;
        end
    end
`else
    assign blocked   = 1'b0;
    assign o_pending = '0;
`endif

    // Ready depends only on registered state and the request index, never on the response.
    assign o_req_ready = (count != FULL) && !blocked;
    assign accept      = i_req_valid && o_req_ready;
    assign push        = accept && req_in_range;
    assign req_bad     = accept && !req_in_range;
    assign pop         = i_rsp_valid && (count != '0);
    assign rsp_bad     = i_rsp_valid && ((count == '0) || i_rsp_err);
    assign wr_fire     = pop && !i_rsp_err;
    assign head_onehot = NREGS'(1) << head;
    assign count_next  = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_wr_addr_c <= '0;
            o_wr_data_c <= '0;
            o_err       <= 1'b0;
            o_err_idx   <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_wr_addr_c <= wr_fire ? head_onehot : '0;
            if (wr_fire) begin
                o_wr_data_c <= i_rsp_data;
            end
            o_err <= req_bad || rsp_bad;
            // A response error takes the index slot over a same-cycle request error.
            if (rsp_bad) begin
                o_err_idx <= (count == '0) ? ZAP_VIOL_IDX : head;
            end else if (req_bad) begin
                o_err_idx <= i_req_idx;
            end
            o_busy <= (count_next != '0) || wr_fire;
        end
    end

endmodule

// File: tb/tb_zap_bg_load_writer.sv
// Scoreboard bench for zap_bg_load_writer; expectations follow ZAP_BG_LOAD_SCOREBOARD_EN when defined.
module tb_zap_bg_load_writer;
    import zap_bg_load_pkg::*;

    localparam int DEPTH  = 4;
    localparam int NREGS  = 40;
    localparam int DATA_W = 32;
`ifdef ZAP_BG_LOAD_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_req_valid;
    logic [5:0]        i_req_idx;
    logic              o_req_ready;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;
    logic              i_rsp_err;
    logic [NREGS-1:0]  o_wr_addr_c;
    logic [DATA_W-1:0] o_wr_data_c;
    logic [NREGS-1:0]  o_pending;
    logic              o_err;
    logic [5:0]        o_err_idx;
    logic              o_busy;

    typedef struct {
        int                cyc;
        logic [NREGS-1:0]  wr;
        logic [DATA_W-1:0] data;
        logic              err;
        logic [5:0]        err_idx;
    } exp_t;

    exp_t             sb[$];
    int               model_q[$];
    logic [NREGS-1:0] mpend;
    logic [NREGS-1:0] defer_cur;
    int               cyc = 0;
    int               n_vec = 0;
    int               n_miss = 0;

    zap_bg_load_writer #(.DEPTH(DEPTH), .NREGS(NREGS), .DATA_W(DATA_W)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_idx   (i_req_idx),
        .o_req_ready (o_req_ready),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .i_rsp_err   (i_rsp_err),
        .o_wr_addr_c (o_wr_addr_c),
        .o_wr_data_c (o_wr_data_c),
        .o_pending   (o_pending),
        .o_err       (o_err),
        .o_err_idx   (o_err_idx),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the entry scheduled for this cycle, flags anything unscheduled.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset) begin
            e = '{cyc: cyc, wr: '0, data: '0, err: 1'b0, err_idx: '0};
            if (sb.size() > 0 && sb[0].cyc <= cyc) e = sb.pop_front();
            if (e.cyc != cyc) check("sb_timing", 64'(e.cyc), 64'(cyc));
            if (e.err || e.wr != '0 || o_err || o_wr_addr_c != '0) begin
                check("wr_addr", 64'(o_wr_addr_c), 64'(e.wr));
                if (e.wr != '0) check("wr_data", 64'(o_wr_data_c), 64'(e.data));
                check("err", 64'(o_err), 64'(e.err));
                if (e.err) check("err_idx", 64'(o_err_idx), 64'(e.err_idx));
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the following posedge+1.
    task automatic cycle(input bit rv, input int ridx, input bit sv,
                         input logic [DATA_W-1:0] sdata, input bit serr);
        bit               exp_ready;
        bit               acc;
        bit               rsp_hit_err;
        int               head;
        exp_t             e;
        logic [NREGS-1:0] err_now;
        logic [NREGS-1:0] set_now;
        logic [NREGS-1:0] defer_next;
        i_req_valid = rv;
        i_req_idx   = 6'(ridx);
        i_rsp_valid = sv;
        i_rsp_data  = sdata;
        i_rsp_err   = serr;
        exp_ready = (model_q.size() != DEPTH) && !(SB && ridx < NREGS && mpend[ridx]);
        @(negedge i_clk);
        check("req_ready", 64'(o_req_ready), 64'(exp_ready));
        check("pending", 64'(o_pending), SB ? 64'(mpend) : 64'd0);
        check("busy", 64'(o_busy), 64'(model_q.size() != 0 || defer_cur != '0));
        e = '{cyc: cyc + 1, wr: '0, data: '0, err: 1'b0, err_idx: '0};
        err_now = '0;
        set_now = '0;
        defer_next = '0;
        rsp_hit_err = 1'b0;
        acc = rv && exp_ready;
        if (sv) begin
            if (model_q.size() == 0) begin
                e.err = 1'b1;
                e.err_idx = 6'h3F;
                rsp_hit_err = 1'b1;
            end else begin
                head = model_q.pop_front();
                if (serr) begin
                    e.err = 1'b1;
                    e.err_idx = 6'(head);
                    rsp_hit_err = 1'b1;
                    err_now[head] = 1'b1;
                end else begin
                    e.wr[head] = 1'b1;
                    e.data = sdata;
                    defer_next[head] = 1'b1;
                end
            end
        end
        if (acc) begin
            if (ridx >= NREGS) begin
                if (!rsp_hit_err) begin
                    e.err = 1'b1;
                    e.err_idx = 6'(ridx);
                end
            end else begin
                model_q.push_back(ridx);
                set_now[ridx] = 1'b1;
            end
        end
        if (e.err || e.wr != '0) sb.push_back(e);
        @(posedge i_clk);
        #1;
        mpend = (mpend & ~defer_cur & ~err_now) | set_now;
        defer_cur = defer_next;
        i_req_valid = 1'b0;
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic req(input int idx);
        cycle(1'b1, idx, 1'b0, '0, 1'b0);
    endtask

    task automatic rsp(input logic [DATA_W-1:0] d, input bit e);
        cycle(1'b0, 0, 1'b1, d, e);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_addr"}, 64'(o_wr_addr_c), 64'd0);
        check({tag, "_wr_data"}, 64'(o_wr_data_c), 64'd0);
        check({tag, "_pending"}, 64'(o_pending), 64'd0);
        check({tag, "_err"}, 64'(o_err), 64'd0);
        check({tag, "_err_idx"}, 64'(o_err_idx), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_ready"}, 64'(o_req_ready), 64'd1);
    endtask

    task automatic model_reset();
        model_q.delete();
        sb.delete();
        mpend = '0;
        defer_cur = '0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_req_valid = 1'b0;
        i_req_idx = '0;
        i_rsp_valid = 1'b0;
        i_rsp_data = '0;
        i_rsp_err = 1'b0;
        model_reset();
        #3;
        check_reset_values("por");
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // Single load to r5.
        req(5);
        idle();
        rsp(32'hDEAD_BEEF, 1'b0);
        idle();
        idle();

        // Fill, back-pressure with a same-cycle pop, then back-to-back drain.
        for (int i = 1; i <= 4; i++) req(i);
        cycle(1'b1, 6, 1'b1, 32'h1111_0001, 1'b0);
        rsp(32'h1111_0002, 1'b0);
        rsp(32'h1111_0003, 1'b0);
        rsp(32'h1111_0004, 1'b0);
        idle();
        idle();

        // Bus error on r7.
        req(7);
        idle();
        rsp(32'hBAD0_0007, 1'b1);
        idle();

        // Illegal request, spurious response, and error collisions.
        req(45);
        idle();
        rsp(32'h0, 1'b0);
        req(8);
        cycle(1'b1, 50, 1'b1, 32'h0, 1'b1);
        cycle(1'b1, 60, 1'b1, 32'h0, 1'b0);
        idle();

        // Duplicate index 9.
        req(9);
        req(9);
        cycle(1'b1, 9, 1'b1, 32'h0909_0001, 1'b0);
        req(9);
        req(9);
        while (model_q.size() > 0) rsp(32'h0909_0000 + 32'(model_q.size()), 1'b0);
        idle();
        idle();

        // Asynchronous reset with three loads still queued and a write pulse live.
        for (int i = 10; i <= 13; i++) req(i);
        rsp(32'h1234_5678, 1'b0);
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        idle();
        idle();
        rsp(32'h5555_AAAA, 1'b0);
        idle();

        // Random mix of legal/illegal requests and responses.
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 47)),
                  1'($urandom_range(0, 2) == 0), 32'($urandom), 1'($urandom_range(0, 7) == 0));
        end
        while (model_q.size() > 0) rsp(32'($urandom), 1'b0);
        idle();
        idle();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
